// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the input conditioner: debounce FSM state
// encodings and default parameter values, used by the RTL and the bench.
package input_conditioner_pkg;

    // Per-channel debounce FSM states (2-bit encoding)
    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b10,
        WAIT_LO   = 2'b11
    } deb_state_t;

    // Default number of consecutive stable synchronized samples
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    // Default debounce counter width
    localparam int DEFAULT_CNT_W = 8;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_channel.sv
// One debounce channel: 2-flop synchronizer, 4-state debounce FSM with
// counter, registered clean level and registered rise pulse.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    // Count value at which a WAIT state completes the transition
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Count loaded on entering a WAIT state. With a single required sample
    // the WAIT state must still last one cycle, so it enters already at the
    // terminal count instead of 1 (keeps the counter within range).
    localparam logic [CNT_W-1:0] CNT_ENTRY = (DEBOUNCE_CYCLES == 1) ? '0 : CNT_W'(1);

    logic             r_s1;
    logic             r_s2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             r_rise;

    // Two-flop synchronizer for the asynchronous raw input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM with counter, registered level and one-cycle rise pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STABLE_LO;
            r_count <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            case (r_state)
                STABLE_LO: begin
                    if (r_s2) begin
                        r_state <= WAIT_HI;
                        r_count <= CNT_ENTRY;
                    end else begin
                        r_count <= '0;
                    end
                end
                WAIT_HI: begin
                    if (!r_s2) begin
                        r_state <= STABLE_LO;
                        r_count <= '0;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= STABLE_HI;
                        r_count <= '0;
                        r_level <= 1'b1;
                        r_rise  <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!r_s2) begin
                        r_state <= WAIT_LO;
                        r_count <= CNT_ENTRY;
                    end else begin
                        r_count <= '0;
                    end
                end
                WAIT_LO: begin
                    if (r_s2) begin
                        r_state <= STABLE_HI;
                        r_count <= '0;
                    end else if (r_count == CNT_LAST) begin
                        r_state <= STABLE_LO;
                        r_count <= '0;
                        r_level <= 1'b0;
                    end else begin
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= STABLE_LO;
                    r_count <= '0;
                    r_level <= 1'b0;
                end
            endcase
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Input conditioner: two independent debounced channels (A and B) feeding
// a downstream Mealy FSM, each with a one-cycle rise pulse.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic b_rise
);

    logic w_a;
    logic w_b;
    logic w_a_rise;
    logic w_b_rise;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_a (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (raw_a),
        .o_level (w_a),
        .o_rise  (w_a_rise)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_chan_b (
        .clk     (clk),
        .reset   (reset),
        .i_raw   (raw_b),
        .o_level (w_b),
        .o_rise  (w_b_rise)
    );

    assign a      = w_a;
    assign b      = w_b;
    assign a_rise = w_a_rise;
    assign b_rise = w_b_rise;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4).
module tb_input_conditioner;
    import input_conditioner_pkg::*;

    // Edge (counted from the first edge sampling the new raw level) on
    // which the clean output changes: 2 + 4.
    localparam int EDGE_OUT = 6;

    logic clk;
    logic reset;
    logic raw_a;
    logic raw_b;
    logic a;
    logic b;
    logic a_rise;
    logic b_rise;

    int n_checks;
    int n_errors;

    input_conditioner #(
        .DEBOUNCE_CYCLES (DEFAULT_DEBOUNCE_CYCLES),
        .CNT_W           (DEFAULT_CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .raw_a  (raw_a),
        .raw_b  (raw_b),
        .a      (a),
        .b      (b),
        .a_rise (a_rise),
        .b_rise (b_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        raw_a = 1'b0;
        raw_b = 1'b0;

        // Reset state while reset is held low
        #2;
        check_val("reset_outs", {28'd0, a, b, a_rise, b_rise}, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle with both raw inputs low: all outputs stay 0 for 20 cycles
        for (int e = 1; e <= 20; e++) begin
            tick();
            check_val("idle_outs", {28'd0, a, b, a_rise, b_rise}, 32'h0);
        end

        // Channel A 0->1 held: a rises on edge 6 with a single pulse
        @(negedge clk);
        raw_a = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val("a_rise_seq", {29'd0, a, a_rise, b},
                      {29'd0, (e >= EDGE_OUT), (e == EDGE_OUT), 1'b0});
        end

        // Channel A 1->0 held: a falls on edge 6, no pulse
        @(negedge clk);
        raw_a = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val("a_fall_seq", {30'd0, a, a_rise}, {30'd0, (e < EDGE_OUT), 1'b0});
        end

        // Channel B glitch high for 3 cycles: rejected, no level, no pulse
        @(negedge clk);
        raw_b = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 3) begin
                @(negedge clk);
                raw_b = 1'b0;
            end
            check_val("b_glitch", {30'd0, b, b_rise}, 32'h0);
        end

        // Both channels rise together: same edge, coincident pulses
        @(negedge clk);
        raw_a = 1'b1;
        raw_b = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val("ab_together", {28'd0, a, b, a_rise, b_rise},
                      (e == EDGE_OUT) ? 32'hF : ((e > EDGE_OUT) ? 32'hC : 32'h0));
        end
        @(negedge clk);
        raw_a = 1'b0;
        raw_b = 1'b0;
        repeat (10) tick();
        check_val("ab_back_low", {28'd0, a, b, a_rise, b_rise}, 32'h0);

        // Reset mid-WAIT on channel A, released with raw_a still high
        @(negedge clk);
        raw_a = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check_val("pre_reset_a", {30'd0, a, a_rise}, 32'h0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("mid_reset_outs", {28'd0, a, b, a_rise, b_rise}, 32'h0);
        repeat (2) tick();
        check_val("held_reset_outs", {28'd0, a, b, a_rise, b_rise}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val("post_reset_a", {30'd0, a, a_rise},
                      {30'd0, (e >= EDGE_OUT), (e == EDGE_OUT)});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_input_conditioner
